// File: rtl/frac_div_multi_pkg.sv
// Shared types and the default ratio table for the multi-ratio fractional clock divider.
package frac_div_multi_pkg;

   localparam int RATIO_W = 16;

   typedef struct packed {
      logic [RATIO_W-1:0] mul;
      logic [RATIO_W-1:0] div;
   } ratio_t;

   typedef enum logic {
      SW_IDLE,
      SW_PEND
   } swState_t;

   // Indexed by the DRP stateSel encoding: 2*resolution + rate59 (720p, 1080p, other).
   localparam ratio_t [5:0] DEFAULT_RATIOS = {
      ratio_t'{mul: 16'd3, div: 16'd16},   // other,  59 Hz
      ratio_t'{mul: 16'd1, div: 16'd5},    // other,  60 Hz
      ratio_t'{mul: 16'd2, div: 16'd7},    // 1080p,  59 Hz
      ratio_t'{mul: 16'd1, div: 16'd3},    // 1080p,  60 Hz
      ratio_t'{mul: 16'd3, div: 16'd10},   // 720p,   59 Hz
      ratio_t'{mul: 16'd1, div: 16'd4}     // 720p,   60 Hz
   };

   function automatic int modeW(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frac_div_multi_if.sv
// Mode-request / status bundle of frac_div_multi. Port run exists only with FRACDIV_GATE_EN.
interface frac_div_multi_if
   import frac_div_multi_pkg::*;
#(
   parameter int NMODES = 6
);
   localparam int MW = modeW(NMODES);

   logic [MW-1:0] modeSel;
   logic          modeReq;
`ifdef FRACDIV_GATE_EN
   logic          run;
`endif
   logic          modeBusy;
   logic          reqErr;
   logic [MW-1:0] curMode;
   logic          clkOut;

`ifdef FRACDIV_GATE_EN
   modport master (output modeSel, modeReq, run, input modeBusy, reqErr, curMode, clkOut);
   modport slave  (input modeSel, modeReq, run, output modeBusy, reqErr, curMode, clkOut);
`else
   modport master (output modeSel, modeReq, input modeBusy, reqErr, curMode, clkOut);
   modport slave  (input modeSel, modeReq, output modeBusy, reqErr, curMode, clkOut);
`endif

endinterface

// File: rtl/frac_div_acc.sv
// Phase accumulator: adds 2*mul per cycle, toggles clkOut on each wrap past div,
// freezes low when run drops, and reports the cycle where a pending switch may land.
module frac_div_acc #(
   parameter int ACCW = 16
) (
   input  logic            pxlClk,
   input  logic            rst,
   input  logic [ACCW-1:0] mul,
   input  logic [ACCW-1:0] div,
   input  logic            run,
   input  logic            busy,
   output logic            clkOut,
   output logic            switchNow
);

   logic [ACCW-1:0] acc;
   logic [ACCW:0]   nxt;
   logic [ACCW:0]   wrapped;
   logic            stopped;
   logic            toggle;

   always_comb begin
      nxt       = {1'b0, acc} + {mul, 1'b0};
      wrapped   = nxt - {1'b0, div};
      stopped   = !run && !clkOut;
      toggle    = !stopped && (nxt >= {1'b0, div});
      // Switching only on the falling toggle (or while parked low) keeps every phase full length.
      switchNow = busy && ((toggle && clkOut) || stopped);
   end

   always_ff @(posedge pxlClk) begin
      if (rst) begin
         acc    <= '0;
         clkOut <= 1'b0;
      end else begin
         if (switchNow)
            acc <= '0;
         else if (toggle)
            acc <= wrapped[ACCW-1:0];
         else if (!stopped)
            acc <= nxt[ACCW-1:0];
         if (toggle)
            clkOut <= !clkOut;
      end
   end

endmodule

// File: rtl/frac_div_multi.sv
// Multi-ratio fractional clock divider: clkOut = pxlClk*mul/div from a per-mode table,
// with glitch-free ratio switching. Optional run gate: define FRACDIV_GATE_EN.
module frac_div_multi
   import frac_div_multi_pkg::*;
#(
   parameter int                      NMODES     = 6,
   parameter int                      ACCW       = 16,
   parameter ratio_t [NMODES-1:0]     RATIOS     = DEFAULT_RATIOS,
   parameter int                      RESET_MODE = 0
) (
   input  logic            pxlClk,
   input  logic            rst,
   frac_div_multi_if.slave bus
);

   localparam int MW = modeW(NMODES);

   for (genvar i = 0; i < NMODES; i++) begin : gChk
      if (int'(RATIOS[i].mul) < 1 || 2 * int'(RATIOS[i].mul) > int'(RATIOS[i].div))
         $error("frac_div_multi: ratio %0d needs mul >= 1 and 2*mul <= div", i);
      if ((64'(RATIOS[i].div) << 1) > (64'd1 << ACCW))
         $error("frac_div_multi: ACCW too narrow for ratio %0d", i);
   end

   swState_t      state, stateNxt;
   logic [MW-1:0] pending, pendNxt;
   logic [MW-1:0] curMode, curNxt;
   logic          reqErr, errNxt;
   logic          accept;
   logic          switchNow;
   logic          runGate;
   logic          clkOut;
   ratio_t        curRatio;

`ifdef FRACDIV_GATE_EN
   assign runGate = bus.run;
`else
   assign runGate = 1'b1;
`endif

   assign curRatio = RATIOS[curMode];

   always_comb begin
      stateNxt = state;
      pendNxt  = pending;
      curNxt   = curMode;
      errNxt   = 1'b0;
      accept   = bus.modeReq && (state == SW_IDLE) && (int'(bus.modeSel) < NMODES);
      if (accept) begin
         stateNxt = SW_PEND;
         pendNxt  = bus.modeSel;
      end else if (bus.modeReq) begin
         errNxt = 1'b1;
      end
      // switchNow is only ever raised in SW_PEND, so it never collides with accept.
      if (switchNow) begin
         stateNxt = SW_IDLE;
         curNxt   = pending;
      end
   end

   always_ff @(posedge pxlClk) begin
      if (rst) begin
         state   <= SW_IDLE;
         pending <= '0;
         curMode <= MW'(RESET_MODE);
         reqErr  <= 1'b0;
      end else begin
         state   <= stateNxt;
         pending <= pendNxt;
         curMode <= curNxt;
         reqErr  <= errNxt;
      end
   end

   frac_div_acc #(
      .ACCW (ACCW)
   ) uAcc (
      .pxlClk    (pxlClk),
      .rst       (rst),
      .mul       (ACCW'(curRatio.mul)),
      .div       (ACCW'(curRatio.div)),
      .run       (runGate),
      .busy      (state == SW_PEND),
      .clkOut    (clkOut),
      .switchNow (switchNow)
   );

   assign bus.modeBusy = (state == SW_PEND);
   assign bus.reqErr   = reqErr;
   assign bus.curMode  = curMode;
   assign bus.clkOut   = clkOut;

endmodule

// File: doc/frac_div_multi.md
# frac_div_multi

Multi-ratio fractional clock divider: generates a 50 %-duty-nominal output clock at f(pxlClk)·MUL/DIV from a per-mode ratio table, switching ratios glitch-free on request. Sits in the top unit in place of the single-ratio GBA clock divider, driving gbaClk, so that the GBA clock follows pixel-clock mode changes (59/60 Hz, 720p/1080p/other resolutions) with the correct ratio for each.

## Interface
- NMODES, 6: number of ratio table entries.
- ACCW, 16: accumulator width; must satisfy 2^ACCW ≥ 2·max(DIV); elaboration error otherwise.
- RATIOS, package default table: ratio_t array [NMODES], each {mul, div}, with 2·mul ≤ div and mul ≥ 1 (elaboration check).
- RESET_MODE, 0: mode selected at reset.
- pxlClk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset; clock pxlClk.
- modeSel  in  $clog2(NMODES)  requested mode index, sampled with modeReq.
- modeReq  in  1  single-cycle request strobe.
- run  in  1  output gate (present only with FRACDIV_GATE_EN).
- modeBusy  out  1  switch pending.
- reqErr  out  1  one-cycle pulse: request rejected.
- curMode  out  $clog2(NMODES)  mode currently in effect.
- clkOut  out  1  generated clock, registered.

## Operation
- Reset: acc=0, clkOut=0, curMode=RESET_MODE, modeBusy=0, reqErr=0, pending index=0.
- Each cycle: nxt = acc + 2·mul(curMode). If nxt ≥ div(curMode): acc←nxt−div, clkOut toggles; else acc←nxt. At most one toggle per cycle, guaranteed by 2·mul ≤ div.
- Request accepted when modeReq=1, modeBusy=0, modeSel<NMODES: latch modeSel, modeBusy←1.
- modeReq while modeBusy=1, or modeSel ≥ NMODES: ignored, reqErr pulses next cycle; state unchanged.
- Request for modeSel==curMode: accepted and processed normally (phase realigned).
- Switch point: the cycle in which clkOut toggles 1→0. In that cycle: curMode←pending, acc←0, modeBusy←0. clkOut still toggles to 0; no runt high or low pulse can occur.
- rst mid-switch: pending request discarded, everything returns to reset values.

## Timing
- modeBusy rises 1 cycle after the accepted modeReq.
- Switch latency: ≤ div_old/mul_old + 1 cycles (at most one output period plus one).
- First edge with new ratio: the first rising toggle after the switch, ceil(div_new/(2·mul_new)) cycles after acc reset.
- clkOut is a flop output; jitter ≤ 1 pxlClk period; long-term frequency exact at mul/div.
- reqErr and modeBusy are never 1 in response to the same request.

## Configuration
- FRACDIV_GATE_EN defined: port run exists. When run=0: if clkOut=1, operation continues until the 1→0 toggle, then acc and clkOut freeze (clkOut=0). When run returns to 1, accumulation resumes from the frozen acc on the next cycle. A pending mode switch completes at the stopping 1→0 toggle; if run=0 with clkOut already 0, the switch is applied immediately (acc←0).
- Not defined: no run port; behaves as run=1 permanently.

## Structure
- Shared package: typedef ratio_t (mul, div, ACCW bits each); constant default RATIOS table with GBA ratios per pixel-clock mode, indexed by the same 3-bit stateSel encoding the DRP uses (720p/1080p/other × 60/59 Hz).
- One sub-module: frac_div_acc (accumulator, compare, toggle, run gating); frac_div_multi holds request/pending logic and ratio mux.

## Test plan
- RATIOS[0]={1,4}, reset, 100 cycles -> clkOut toggles every 2 cycles, 25 rising edges, curMode=0.
- Mode {3,10}, 1000 cycles -> 300±1 rising edges; high/low phases each 1 or 2 cycles.
- Request mode 1 ({3,10}) while in mode 0 ({1,4}) with clkOut=1 -> modeBusy high next cycle, switch at following 1→0 toggle, no pulse shorter than 1 cycle, curMode=1.
- Second modeReq while busy, and modeSel=7 with NMODES=6 -> reqErr one-cycle pulse each, curMode/pending unchanged.
- rst asserted while modeBusy=1 -> next cycle clkOut=0, modeBusy=0, curMode=RESET_MODE.
- FRACDIV_GATE_EN: run=0 while clkOut=1 -> clkOut falls at next scheduled toggle then stays 0; run=1 -> edges resume with unchanged acc phase.
